// File: rtl/crc_dec_if.sv
`default_nettype none
// ============================================================================
//  crc_dec_if : frame-start / RAM-read / payload-stream bus of the CRC checker
//  Revision   : 1.0
// ============================================================================
interface crc_dec_if;
    logic        start;
    logic [10:0] addr;
    logic [7:0]  rd_data;
    logic        sts;
    logic [7:0]  D_RX;
    logic        D_RX_ready;
    logic [5:0]  pckt_num;
    logic        done;
    logic        crc_ok;
    logic        len_err;

    modport master (
        output start, rd_data,
        input  addr, sts, D_RX, D_RX_ready, pckt_num, done, crc_ok, len_err
    );

    modport slave (
        input  start, rd_data,
        output addr, sts, D_RX, D_RX_ready, pckt_num, done, crc_ok, len_err
    );
endinterface
`default_nettype wire

// File: rtl/crc_dec.sv
`default_nettype none
// ============================================================================
//  crc_dec  : receive-side CRC-16-CCITT checker and depacketizer
//  Revision : 1.0
// ============================================================================
module crc_dec #(
    parameter logic [10:0] BASE_ADDR = 11'd0
) (
    input  wire logic clk_40mhz,
    input  wire logic reset_n,
    crc_dec_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_LEN  = 3'd2,
        S_PAY  = 3'd3,
        S_CRCH = 3'd4,
        S_CRCL = 3'd5
    } state_t;

    state_t      state_q,    state_d;
    logic        hdr_wait_q, hdr_wait_d;
    logic [10:0] addr_q,     addr_d;
    logic [7:0]  len_q,      len_d;
    logic [7:0]  cnt_q,      cnt_d;
    logic [15:0] crc_q,      crc_d;
    logic        sts_q,      sts_d;
    logic [7:0]  d_rx_q,     d_rx_d;
    logic        d_rx_rdy_q, d_rx_rdy_d;
    logic [5:0]  pckt_num_q, pckt_num_d;
    logic        done_q,     done_d;
    logic        crc_ok_q,   crc_ok_d;
    logic        len_err_q,  len_err_d;

    logic [15:0] crc_next;
    logic [10:0] last_addr;
    logic        addr_more;

    // One byte of CRC-16-CCITT (0x1021), MSB first, unrolled to combinational logic.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    assign crc_next  = crc16_byte(crc_q, bus.rd_data);
    assign last_addr = BASE_ADDR + {3'd0, len_q} + 11'd3;
    assign addr_more = (addr_q != last_addr);

    always_comb begin
        state_d    = state_q;
        hdr_wait_d = hdr_wait_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        sts_d      = sts_q;
        d_rx_d     = d_rx_q;
        d_rx_rdy_d = 1'b0;
        pckt_num_d = pckt_num_q;
        done_d     = 1'b0;
        crc_ok_d   = crc_ok_q;
        len_err_d  = len_err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_HDR;
                    hdr_wait_d = 1'b1;
                    addr_d     = BASE_ADDR;
                    sts_d      = 1'b1;
                    crc_ok_d   = 1'b0;
                    len_err_d  = 1'b0;
                    crc_d      = 16'hFFFF;
                end
            end

            // First HDR cycle only covers the RAM read latency of the header byte.
            S_HDR: begin
                addr_d = addr_q + 11'd1;
                if (hdr_wait_q) begin
                    hdr_wait_d = 1'b0;
                end else begin
                    pckt_num_d = bus.rd_data[5:0];
                    state_d    = S_LEN;
                end
            end

            S_LEN: begin
                addr_d = addr_q + 11'd1;
                if (bus.rd_data == 8'd0) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    len_err_d = 1'b1;
                    crc_ok_d  = 1'b0;
                    sts_d     = 1'b0;
                end else begin
                    len_d   = bus.rd_data;
                    cnt_d   = 8'd0;
                    state_d = S_PAY;
                end
            end

            S_PAY: begin
                if (addr_more) begin
                    addr_d = addr_q + 11'd1;
                end
                d_rx_d     = bus.rd_data;
                d_rx_rdy_d = 1'b1;
                crc_d      = crc_next;
                cnt_d      = cnt_q + 8'd1;
                if (cnt_q == len_q - 8'd1) begin
                    state_d = S_CRCH;
                end
            end

            S_CRCH: begin
                if (addr_more) begin
                    addr_d = addr_q + 11'd1;
                end
                crc_d   = crc_next;
                state_d = S_CRCL;
            end

            // Feeding the received CRC through the register leaves a zero residue on a match.
            S_CRCL: begin
                if (addr_more) begin
                    addr_d = addr_q + 11'd1;
                end
                crc_d    = crc_next;
                crc_ok_d = (crc_next == 16'h0000);
                done_d   = 1'b1;
                sts_d    = 1'b0;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_40mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            hdr_wait_q <= 1'b0;
            addr_q     <= BASE_ADDR;
            len_q      <= 8'd0;
            cnt_q      <= 8'd0;
            crc_q      <= 16'hFFFF;
            sts_q      <= 1'b0;
            d_rx_q     <= 8'd0;
            d_rx_rdy_q <= 1'b0;
            pckt_num_q <= 6'd0;
            done_q     <= 1'b0;
            crc_ok_q   <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_wait_q <= hdr_wait_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            sts_q      <= sts_d;
            d_rx_q     <= d_rx_d;
            d_rx_rdy_q <= d_rx_rdy_d;
            pckt_num_q <= pckt_num_d;
            done_q     <= done_d;
            crc_ok_q   <= crc_ok_d;
            len_err_q  <= len_err_d;
        end
    end

    assign bus.addr       = addr_q;
    assign bus.sts        = sts_q;
    assign bus.D_RX       = d_rx_q;
    assign bus.D_RX_ready = d_rx_rdy_q;
    assign bus.pckt_num   = pckt_num_q;
    assign bus.done       = done_q;
    assign bus.crc_ok     = crc_ok_q;
    assign bus.len_err    = len_err_q;

endmodule
`default_nettype wire

// File: doc/crc_dec.md
# crc_dec

Receive-side CRC checker and depacketizer, the counterpart of the CRC encoder on the transmit path. When told a received frame is present in the 2048×8 packet RAM, it reads the frame and extracts the packet number. It then streams the payload bytes to the downstream consumer one per clock and checks the trailing CRC-16. It reports pass/fail with a single `done` pulse. The consumer must discard the streamed payload if `crc_ok` is low at `done`.

## Interface
Parameters:
- `BASE_ADDR`, default 11'd0: RAM address of the first byte of the frame.

Ports:
- `clk_40mhz`  in  1  system clock. All logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame present in RAM. Sampled only in IDLE.
- `addr`  out  11  RAM read address, registered.
- `rd_data`  in  8  RAM read data. The RAM has synchronous read, so data for `addr` is valid one cycle later.
- `sts`  out  1  busy. High from `start` acceptance until `done`.
- `D_RX`  out  8  payload byte. Valid while `D_RX_ready` is high.
- `D_RX_ready`  out  1  one-cycle strobe per payload byte.
- `pckt_num`  out  6  `rd_data[5:0]` of the header byte. Held until the next header is read.
- `done`  out  1  one-cycle pulse at the end of the frame.
- `crc_ok`  out  1  CRC check passed. Valid from `done`; held until the next `start` is accepted.
- `len_err`  out  1  length byte was 0. Valid from `done`; held until the next `start` is accepted.

## Operation
Frame layout (offsets are from `BASE_ADDR`; all address arithmetic is mod 2048, so frames wrap past 2047 to 0):
- +0: header. Bits [5:0] are `pckt_num`; bits [7:6] are ignored.
- +1: payload length L, 1..255.
- +2 .. +L+1: payload.
- +L+2: CRC high byte.
- +L+3: CRC low byte.

CRC:
- CRC-16-CCITT: polynomial 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR.
- Covers the payload only.
- Updated one byte per clock with a combinational byte-wise function.
- The two CRC bytes are also fed through the CRC. `crc_ok` = (register == 16'h0000) after the low CRC byte.

FSM states: IDLE, HDR, LEN, PAY, CRCH, CRCL.
- IDLE, `start`=1: go to HDR. Load `addr`=`BASE_ADDR`, set `sts`=1, clear `crc_ok`/`len_err`, set the CRC register to 0xFFFF.
- In every non-IDLE state, `addr` increments by 1 each clock until BASE+L+3 has been issued, then holds.
- HDR: sample `pckt_num`, go to LEN.
- LEN:
  - L=0: go to IDLE. Pulse `done`, set `len_err`=1 and `crc_ok`=0, drop `sts`. No payload is emitted.
  - Otherwise: latch L, zero the byte counter, go to PAY.
- PAY: emit `D_RX`=`rd_data` with a `D_RX_ready` strobe and update the CRC. After the L-th byte go to CRCH.
- CRCH: update the CRC, go to CRCL.
- CRCL: update the CRC, then go to IDLE. Set `crc_ok`, pulse `done`, drop `sts`.
- `start` outside IDLE is ignored. If `start` is held high, the next frame is accepted the cycle `sts` falls.
- `reset_n` low at any time, including mid-frame: go to IDLE immediately. The frame is abandoned and no `done` is issued.

Reset values: `addr`=`BASE_ADDR`; `sts`, `D_RX`, `D_RX_ready`, `pckt_num`, `done`, `crc_ok`, `len_err` all 0.

## Timing
- E0 is the edge at which `start` is sampled high in IDLE. `addr`=BASE from E0.
- Header is sampled at E2, length at E3.
- Payload byte k (k=0..L-1) is sampled at E4+k. `D_RX`/`D_RX_ready` are visible during the cycle after E4+k, so there are L consecutive strobes with no gaps.
- CRC high byte is sampled at E4+L, low byte at E5+L.
- `done`/`crc_ok` are visible from E5+L, so latency is L+5 clocks. `sts` falls at E5+L.
- L=0: `done` and `len_err` are visible from E3. No `D_RX_ready` is emitted.
- The last address issued is BASE+L+3, at E3+L. Addresses BASE+2 and BASE+3 are issued before L is known; this is harmless.
- All outputs are registered. No combinational path from input to output.

## Test plan
1. Nominal frame. `BASE_ADDR`=0, RAM = 0x2A, 0x09, 0x31..0x39 ("123456789"), 0x29, 0xB1; pulse `start`.
   - Expect 9 contiguous strobes with `D_RX` = 0x31..0x39 and `pckt_num`=0x2A.
   - Expect `done` 14 clocks after E0 with `crc_ok`=1, `len_err`=0, and `sts` low.
2. Corrupted CRC. Same as case 1 with the low CRC byte set to 0xB0.
   - Expect an identical payload stream, then `done` with `crc_ok`=0.
3. Length 0. Length byte = 0x00.
   - Expect `done` 3 clocks after E0 with `len_err`=1, `crc_ok`=0, and no `D_RX_ready`.
4. Address wrap. `BASE_ADDR`=2046, L=1.
   - Expect `addr` sequence 2046, 2047, 0, 1, 2 and correct `crc_ok`.
5. `start` during and after a frame.
   - `start` pulsed mid-frame: ignored, no change in output timing.
   - `start` held high: back-to-back frames, with the second E0 at the cycle `sts` falls.
6. Reset mid-payload. `reset_n` low after the 3rd strobe.
   - Expect all outputs at reset values and no `done`.
   - After release, `start` decodes case 1 correctly.
